// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared definitions for the iterative AES decryption sequencer:
// controller state encoding, legal round counts and inverse-cipher byte helpers.
package aes_inv_round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_INIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_LAST  = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_e;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Byte 0x00 lives in the top 8 bits, so entry b sits at bit offset 8*(255-b).
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // One column, row 0 in the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
            gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
            gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
            gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round_ctrl_round
  import aes_inv_round_ctrl_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] shifted_s;
  logic [127:0] subbed_s;
  logic [127:0] keyed_s;
  logic [127:0] mixed_s;

  // Byte (row r, column c) is byte 4c+r; row r rotates right by r columns.
  always_comb begin
    shifted_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted_s[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    subbed_s = '0;
    for (int i = 0; i < 16; i++) begin
      subbed_s[127-8*i -: 8] = inv_sbox(shifted_s[127-8*i -: 8]);
    end
  end

  assign keyed_s = subbed_s ^ rk_i;

  always_comb begin
    mixed_s = '0;
    for (int c = 0; c < 4; c++) begin
      mixed_s[127-32*c -: 32] = inv_mix_col(keyed_s[127-32*c -: 32]);
    end
  end

  assign state_o = last_i ? keyed_s : mixed_s;

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption sequencer: one block at a time, one inverse round per
// clock, round keys fetched from an external synchronous key store.
module aes_inv_round_ctrl
  import aes_inv_round_ctrl_pkg::*;
#(
  parameter int NR    = 10,
  parameter int RKA_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_rdy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic [RKA_W-1:0] rk_addr,
  input  logic [127:0]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  output logic [RKA_W-1:0] round
);

  if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
    $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
  end
  if ((1 << RKA_W) <= NR) begin : g_bad_rka_w
    $error("aes_inv_round_ctrl: RKA_W too narrow to address round key NR");
  end

  localparam logic [RKA_W-1:0] NR_A  = RKA_W'(NR);
  localparam logic [RKA_W-1:0] NR_M1 = RKA_W'(NR - 1);
  localparam logic [RKA_W-1:0] ONE_A = RKA_W'(1);
  localparam logic [RKA_W-1:0] ZERO_A = RKA_W'(0);

  ctrl_state_e      state_q, state_d;
  logic [RKA_W-1:0] round_q, round_d;
  logic [127:0]     data_q, data_d;
  logic [127:0]     round_out_s;
  logic             last_s;

  assign last_s = (state_q == ST_LAST);

  aes_inv_round_ctrl_round u_round (
    .state_i (data_q),
    .rk_i    (rk_data),
    .last_i  (last_s),
    .state_o (round_out_s)
  );

  // Key address always runs one step ahead of the round that consumes it.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    data_d   = data_q;
    rk_addr  = NR_A;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = key_rdy;
        if (in_valid && key_rdy) begin
          data_d  = in_data;
          round_d = NR_A;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        data_d  = data_q ^ rk_data;
        rk_addr = NR_M1;
        round_d = NR_M1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        data_d  = round_out_s;
        rk_addr = round_q - ONE_A;
        round_d = round_q - ONE_A;
        if (round_q == ONE_A) begin
          state_d = ST_LAST;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_LAST: begin
        data_d  = round_out_s;
        rk_addr = ZERO_A;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, round counter and data register; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= ZERO_A;
      data_q  <= 128'h0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench: a forward AES-128 model (S-box derived from GF(2^8)
// arithmetic) encrypts random plaintext; the DUT must recover it.
module tb_aes_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, key_rdy, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, out_data;
  logic [3:0]   rk_addr, round;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk_mem [16];

  aes_inv_round_ctrl #(.NR(10), .RKA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_rdy(key_rdy), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rk_addr(rk_addr), .rk_data(rk_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .round(round)
  );

  always #5 clk = ~clk;

  // Synchronous key store: data appears one cycle after the address.
  always @(posedge clk) rk_data <= rk_mem[rk_addr];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] x;
    for (int a = 0; a < 256; a++) begin
      x = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) x = 8'(b);
      sbox[a] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_mem[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gf_mul(s[4*c], 8'h02) ^ gf_mul(s[4*c+1], 8'h03) ^ s[4*c+2] ^ s[4*c+3];
          t[4*c+1] = s[4*c] ^ gf_mul(s[4*c+1], 8'h02) ^ gf_mul(s[4*c+2], 8'h03) ^ s[4*c+3];
          t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gf_mul(s[4*c+2], 8'h02) ^ gf_mul(s[4*c+3], 8'h03);
          t[4*c+3] = gf_mul(s[4*c], 8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gf_mul(s[4*c+3], 8'h02);
        end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_mem[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers one block, waits for its plaintext and retires it with out_ready=1.
  task automatic send_block(input logic [127:0] ct, output logic [127:0] pt_o, output int lat_o);
    int n;
    in_data = ct; in_valid = 1'b1; out_ready = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; lat_o = 0;
    while (!out_valid && lat_o < 100) begin @(posedge clk); #1; lat_o++; end
    pt_o = out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (round !== 4'd0) begin failures++; $display("FAIL reset_round got=%0d exp=0", round); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_keylow got=%0b exp=0", in_ready); end
    key_rdy = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_keyhigh got=%0b exp=1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_fips();
    int          lat, n;
    logic [3:0]  tr [12];
    logic [3:0]  exp_a;
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    in_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; in_valid = 1'b1; out_ready = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    tr[0] = rk_addr;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0;
    for (int k = 1; k < 12; k++) tr[k] = 4'hf;
    while (!out_valid && lat < 100) begin
      if (lat <= 10) tr[lat+1] = rk_addr;
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat !== 12) begin failures++; $display("FAIL fips_latency got=%0d exp=12", lat); end
    checks++; if (out_data !== 128'h00112233445566778899aabbccddeeff)
      begin failures++; $display("FAIL fips_plaintext got=%h exp=00112233445566778899aabbccddeeff", out_data); end
    for (int k = 0; k < 12; k++) begin
      exp_a = (k < 2) ? 4'd10 : 4'(11 - k);
      checks++; if (tr[k] !== exp_a) begin failures++; $display("FAIL fips_rk_addr[%0d] got=%0d exp=%0d", k, tr[k], exp_a); end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fips_return_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_key_rdy();
    logic [127:0] pt;
    int           lat;
    load_key(rand128()); pt = rand128();
    key_rdy = 1'b0; in_data = encrypt(pt); in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL keyrdy_in_ready cyc%0d got=%0b exp=0", i, in_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL keyrdy_no_accept cyc%0d got=%0b exp=0", i, busy); end
    end
    key_rdy = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL keyrdy_raise got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL keyrdy_accept got=%0b exp=1", busy); end
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (out_data !== pt) begin failures++; $display("FAIL keyrdy_data got=%h exp=%h", out_data, pt); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] pt;
    int           lat, n;
    load_key(rand128()); pt = rand128();
    in_data = encrypt(pt); in_valid = 1'b1; out_ready = 1'b0; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_data = rand128(); lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 12) begin failures++; $display("FAIL bp_latency got=%0d exp=12", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held cyc%0d got=%0b exp=1", i, out_valid); end
      checks++; if (out_data !== pt) begin failures++; $display("FAIL bp_data_stable cyc%0d got=%h exp=%h", i, out_data, pt); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc%0d got=%0b exp=0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt [3];
    logic [127:0] got [3];
    int           acc_cyc [3];
    int           idx, n_out;
    logic         acc, ovd;
    logic [127:0] cap;
    load_key(rand128());
    for (int i = 0; i < 3; i++) begin pt[i] = rand128(); got[i] = 128'h0; acc_cyc[i] = 0; end
    idx = 0; n_out = 0; out_ready = 1'b1; in_data = encrypt(pt[0]); in_valid = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      acc = in_valid && in_ready;
      ovd = out_valid && out_ready;
      cap = out_data;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[idx] = cyc; idx++;
        if (idx < 3) in_data = encrypt(pt[idx]); else in_valid = 1'b0;
      end
      if (ovd && n_out < 3) begin got[n_out] = cap; n_out++; end
    end
    in_valid = 1'b0;
    checks++; if (idx !== 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", idx); end
    checks++; if (n_out !== 3) begin failures++; $display("FAIL b2b_outputs got=%0d exp=3", n_out); end
    for (int i = 1; i < 3; i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 14)
        begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=14", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== pt[i]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got[i], pt[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt, res;
    int           lat, n;
    load_key(rand128()); pt = rand128();
    in_data = encrypt(rand128()); in_valid = 1'b1; out_ready = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; n = 0;
    while (!(busy && round == 4'd5) && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (round !== 4'd5) begin failures++; $display("FAIL rstmid_reach_round5 got=%0d exp=5", round); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL rstmid_out_data got=%h exp=0", out_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_partial got=%0b exp=0", out_valid); end
    send_block(encrypt(pt), res, lat);
    checks++; if (res !== pt) begin failures++; $display("FAIL rstmid_next_data got=%h exp=%h", res, pt); end
    checks++; if (lat !== 12) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=12", lat); end
  endtask

  task automatic test_random();
    logic [127:0] pt, res;
    int           lat;
    for (int i = 0; i < 4; i++) begin
      load_key(rand128()); pt = rand128();
      send_block(encrypt(pt), res, lat);
      checks++; if (res !== pt) begin failures++; $display("FAIL random%0d_data got=%h exp=%h", i, res, pt); end
      checks++; if (lat !== 12) begin failures++; $display("FAIL random%0d_latency got=%0d exp=12", i, lat); end
    end
  endtask

  initial begin
    rst_n = 1'b0; key_rdy = 1'b0; in_valid = 1'b0; in_data = 128'h0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) rk_mem[i] = 128'h0;
    build_sbox();
    test_reset();
    test_fips();
    test_key_rdy();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
